// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Pure definitions: no logic, no latency, no flow control.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic       AN_OFF    = 1'b1;
   localparam logic       DP_OFF    = 1'b1;

   // Keeps counters at least one bit wide when a parameter degenerates to 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_bcd_to_7seg.sv
// BCD to active-low 7-segment decoder, segments {g..a}; non-BCD codes go dark.
// Purely combinational, zero latency; no handshake.
module bcd_to_7seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of a common-anode active-low display with blank gaps between digits.
// Pins are registered from next-state; loads are held and applied tear-free at frame boundaries.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_suppress,
   input  logic                    load,
   output logic                    pending,
   output logic                    frame_done,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp
);

   localparam int CNT_W = cnt_width(REFRESH_DIV);
   localparam int IDX_W = cnt_width(NUM_DIGITS);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

   scan_state_t           state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   digits_t               hold_val_q, hold_val_d;
   logic [NUM_DIGITS-1:0] hold_dp_q, hold_dp_d;
   logic                  hold_lz_q, hold_lz_d;
   digits_t               shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
   logic                  shadow_lz_q, shadow_lz_d;
   logic                  pending_q, pending_d;

   logic                  frame_done_q, frame_done_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   logic                  frame_end;
   logic                  xfer;
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  all_zero;
   logic [3:0]            dec_bcd;
   logic [6:0]            dec_seg;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      frame_end = 1'b0;
      if (!en) begin
         state_d = S_OFF;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d = S_BLANK;
               idx_d   = '0;
               cnt_d   = '0;
            end
            S_BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == BLANK_LAST) begin
                  state_d = S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (cnt_q == SLOT_LAST) begin
                  state_d   = S_BLANK;
                  cnt_d     = '0;
                  frame_end = (idx_q == IDX_LAST);
                  idx_d     = frame_end ? '0 : idx_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = S_OFF;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // While dark there is no frame to tear, so a captured load moves straight across.
   always_comb begin
      xfer         = pending_q && (frame_end || (state_q == S_OFF));
      hold_val_d   = load ? digits_t'(value_in) : hold_val_q;
      hold_dp_d    = load ? dp_in : hold_dp_q;
      hold_lz_d    = load ? lz_suppress : hold_lz_q;
      pending_d    = load || (pending_q && !xfer);
      shadow_val_d = xfer ? hold_val_q : shadow_val_q;
      shadow_dp_d  = xfer ? hold_dp_q : shadow_dp_q;
      shadow_lz_d  = xfer ? hold_lz_q : shadow_lz_q;
      frame_done_d = frame_end;
   end

   always_comb begin
      lz_mask  = '0;
      all_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         all_zero   = all_zero && (shadow_val_q[i] == 4'h0);
         lz_mask[i] = shadow_lz_q && all_zero;
      end
   end

   assign dec_bcd = shadow_val_q[idx_d];

   bcd_to_7seg u_dec (
      .bcd (dec_bcd),
      .seg (dec_seg)
   );

   always_comb begin
      an_d  = {NUM_DIGITS{AN_OFF}};
      seg_d = SEG_BLANK;
      dp_d  = DP_OFF;
      if ((state_d == S_DRIVE) && !lz_mask[idx_d]) begin
         an_d[idx_d] = ~AN_OFF;
         seg_d       = dec_seg;
         dp_d        = ~shadow_dp_q[idx_d];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_BLANK;
         idx_q        <= '0;
         cnt_q        <= '0;
         hold_val_q   <= '0;
         hold_dp_q    <= '0;
         hold_lz_q    <= 1'b0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         shadow_lz_q  <= 1'b0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
         an_q         <= {NUM_DIGITS{AN_OFF}};
         seg_q        <= SEG_BLANK;
         dp_q         <= DP_OFF;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         hold_val_q   <= hold_val_d;
         hold_dp_q    <= hold_dp_d;
         hold_lz_q    <= hold_lz_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         shadow_lz_q  <= shadow_lz_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
      end
   end

   assign pending    = pending_q;
   assign frame_done = frame_done_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboarded bench for seven_seg_scan_ctrl with a 4-digit, 8-cycle-slot, 2-cycle-blank setup.
module tb_seven_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        lz_suppress;
   logic        load;
   logic        pending;
   logic        frame_done;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      int         k;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .value_in    (value_in),
      .dp_in       (dp_in),
      .lz_suppress (lz_suppress),
      .load        (load),
      .pending     (pending),
      .frame_done  (frame_done),
      .an          (an),
      .seg         (seg),
      .dp          (dp)
   );

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b100_0000;
         4'd1:    return 7'b111_1001;
         4'd2:    return 7'b010_0100;
         4'd3:    return 7'b011_0000;
         4'd4:    return 7'b001_1001;
         4'd5:    return 7'b001_0010;
         4'd6:    return 7'b000_0010;
         4'd7:    return 7'b111_1000;
         4'd8:    return 7'b000_0000;
         4'd9:    return 7'b001_0000;
         default: return 7'h7F;
      endcase
   endfunction

   // Expected pins k cycles into a frame; k = 32 is the first cycle of the next frame.
   function automatic exp_t model(input logic [15:0] v, input logic [3:0] d, input logic l,
                                  input int k, input logic fd0);
      exp_t e;
      int   slot;
      int   w;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.fd  = 1'b0;
      e.k   = k;
      if (k >= ND * RD) begin
         e.fd = 1'b1;
         return e;
      end
      slot = k / RD;
      w    = k % RD;
      if (k == 0) e.fd = fd0;
      if (w >= BC && !(l && slot > 0 && (v >> (4 * slot)) == 16'h0)) begin
         e.an  = ~(4'b0001 << slot);
         e.seg = seg_of(v[4*slot +: 4]);
         e.dp  = ~d[slot];
      end
      return e;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic push_slots(input logic [15:0] v, input logic [3:0] d, input logic l,
                             input int from_k, input int to_k, input logic fd0);
      for (int k = from_k; k <= to_k; k++) sb.push_back(model(v, d, l, k, fd0));
   endtask

   task automatic push_dark(input int n);
      exp_t e;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.fd  = 1'b0;
      e.k   = -1;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic l);
      value_in    = v;
      dp_in       = d;
      lz_suppress = l;
      load        = 1'b1;
      step();
      load        = 1'b0;
   endtask

   task automatic wait_frame_done(input string tag);
      int i;
      i = 0;
      while (frame_done !== 1'b1 && i < 100) begin
         step();
         i++;
      end
      n_tests++;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_frame_done: got %b after %0d cycles, want 1", tag, frame_done, i);
      end
   endtask

   // Each pin sample after a rising edge is checked against the oldest queued expectation.
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_tests++;
         if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
            n_fail++;
            $display("FAIL scan k=%0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                     e.k, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
         end
      end
   end

   task automatic test_reset();
      rst_n       = 1'b0;
      en          = 1'b1;
      load        = 1'b1;
      value_in    = 16'h1234;
      dp_in       = 4'hF;
      lz_suppress = 1'b1;
      run(3);
      n_tests++;
      if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
      n_tests++;
      if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg); end
      n_tests++;
      if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
      n_tests++;
      if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", pending); end
      n_tests++;
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      rst_n = 1'b1;
      load  = 1'b0;
      step();
      n_tests++;
      if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_release_pending: got %b want 0", pending); end
   endtask

   task automatic test_basic_scan();
      do_load(16'h1234, 4'h0, 1'b0);
      n_tests++;
      if (pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending_set: got %b want 1", pending); end
      wait_frame_done("basic");
      n_tests++;
      if (pending !== 1'b0) begin n_fail++; $display("FAIL basic_pending_clear: got %b want 0", pending); end
      push_slots(16'h1234, 4'h0, 1'b0, 1, 32, 1'b1);
      run(32);
   endtask

   task automatic test_lz_suppress();
      do_load(16'h0007, 4'h0, 1'b1);
      wait_frame_done("lz7");
      push_slots(16'h0007, 4'h0, 1'b1, 1, 32, 1'b1);
      run(32);
      do_load(16'h0000, 4'h0, 1'b1);
      wait_frame_done("lz0");
      push_slots(16'h0000, 4'h0, 1'b1, 1, 32, 1'b1);
      run(32);
   endtask

   task automatic test_tear_free();
      do_load(16'h5678, 4'h0, 1'b0);
      wait_frame_done("tear");
      push_slots(16'h5678, 4'h0, 1'b0, 1, 32, 1'b1);
      for (int k = 0; k < 32; k++) begin
         if (k == 10) begin value_in = 16'h1111; load = 1'b1; end
         if (k == 11) load = 1'b0;
         if (k == 13) begin value_in = 16'h2222; load = 1'b1; end
         if (k == 14) load = 1'b0;
         if (k == 20) begin
            n_tests++;
            if (pending !== 1'b1) begin n_fail++; $display("FAIL tear_pending_mid: got %b want 1", pending); end
         end
         step();
      end
      n_tests++;
      if (pending !== 1'b0) begin n_fail++; $display("FAIL tear_pending_applied: got %b want 0", pending); end
      push_slots(16'h2222, 4'h0, 1'b0, 1, 32, 1'b1);
      run(32);
   endtask

   task automatic test_nonbcd_dp();
      do_load(16'h00A0, 4'b0010, 1'b0);
      wait_frame_done("nonbcd");
      push_slots(16'h00A0, 4'b0010, 1'b0, 1, 32, 1'b1);
      run(32);
   endtask

   task automatic test_enable();
      do_load(16'h1234, 4'h0, 1'b0);
      wait_frame_done("enable");
      push_slots(16'h1234, 4'h0, 1'b0, 1, 20, 1'b1);
      run(20);
      en = 1'b0;
      push_dark(3);
      step();
      value_in = 16'h4321;
      dp_in    = 4'h0;
      load     = 1'b1;
      step();
      load = 1'b0;
      n_tests++;
      if (pending !== 1'b1) begin n_fail++; $display("FAIL off_pending_set: got %b want 1", pending); end
      step();
      n_tests++;
      if (pending !== 1'b0) begin n_fail++; $display("FAIL off_pending_clear: got %b want 0", pending); end
      en = 1'b1;
      push_slots(16'h4321, 4'h0, 1'b0, 0, 32, 1'b0);
      run(33);
   endtask

   task automatic test_reset_mid();
      do_load(16'h1234, 4'h0, 1'b0);
      wait_frame_done("rstmid");
      push_slots(16'h1234, 4'h0, 1'b0, 1, 20, 1'b1);
      run(19);
      do_load(16'h9999, 4'hF, 1'b0);
      push_slots(16'h0000, 4'h0, 1'b0, 0, 32, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_tests++;
      if (pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending: got %b want 0", pending); end
      run(32);
   endtask

   initial begin
      rst_n       = 1'b0;
      en          = 1'b0;
      load        = 1'b0;
      value_in    = '0;
      dp_in       = '0;
      lz_suppress = 1'b0;
      test_reset();
      test_basic_scan();
      test_lz_suppress();
      test_tear_free();
      test_nonbcd_dp();
      test_enable();
      test_reset_mid();
      step();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
